// File: rtl/bmp_pkg.sv
// Shared constants and FSM encoding for the bitmap scanout path.
package bmp_pkg;

    localparam int unsigned ROW_W  = 48;
    localparam int unsigned ROWS   = 32;
    localparam int unsigned BMP_W  = ROW_W * ROWS;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned IDX_W  = $clog2(ROWS);
    localparam int unsigned OFS_W  = $clog2(BMP_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        WAIT   = 2'd2,
        STREAM = 2'd3
    } state_t;

endpackage

// File: rtl/bmp_row_mux.sv
// Selects the current row out of the captured bitmap buffer (combinational).
module bmp_row_mux
    import bmp_pkg::*;
(
    input  logic [BMP_W-1:0] buffer,
    input  logic [IDX_W-1:0] row_idx,
    output logic [ROW_W-1:0] row_data
);

    logic [OFS_W-1:0] base;

    assign base     = OFS_W'(row_idx) * OFS_W'(ROW_W);
    assign row_data = buffer[base +: ROW_W];

endmodule

// File: rtl/bitmap_scanout.sv
// Reads one bitmap from memory on start and streams it row by row over valid/ready.
// Optional BMP_SCANOUT_LOOP_EN: re-fetch and re-stream until loop_stop is seen.
module bitmap_scanout
    import bmp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] bmp_addr,
`ifdef BMP_SCANOUT_LOOP_EN
    input  logic              loop_stop,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_rdaddr,
    output logic              mem_rden,
    input  logic [BMP_W-1:0]  mem_q,
    output logic [ROW_W-1:0]  row_data,
    output logic [IDX_W-1:0]  row_idx,
    output logic              row_last,
    output logic              row_valid,
    input  logic              row_ready
);

    state_t             state, state_nxt;
    logic               busy_nxt, done_nxt, rden_nxt, last_nxt, valid_nxt;
    logic [ADDR_W-1:0]  rdaddr_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic [BMP_W-1:0]   buffer;
    logic               stop_req;
`ifdef BMP_SCANOUT_LOOP_EN
    logic               stop_seen, stop_nxt;
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_rden   <= 1'b0;
            mem_rdaddr <= '0;
            row_idx    <= '0;
            row_last   <= 1'b0;
            row_valid  <= 1'b0;
            buffer     <= '0;
`ifdef BMP_SCANOUT_LOOP_EN
            stop_seen  <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            mem_rden   <= rden_nxt;
            mem_rdaddr <= rdaddr_nxt;
            row_idx    <= idx_nxt;
            row_last   <= last_nxt;
            row_valid  <= valid_nxt;
            if (state == WAIT) begin
                buffer <= mem_q;
            end
`ifdef BMP_SCANOUT_LOOP_EN
            stop_seen  <= stop_nxt;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt  = state;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        rden_nxt   = 1'b0;
        rdaddr_nxt = mem_rdaddr;
        idx_nxt    = row_idx;
        last_nxt   = row_last;
        valid_nxt  = row_valid;
`ifdef BMP_SCANOUT_LOOP_EN
        // loop_stop is sticky for the remainder of the current pass
        stop_nxt   = stop_seen | (busy & loop_stop);
        stop_req   = stop_seen | loop_stop;
`else
        stop_req   = 1'b1;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    rdaddr_nxt = bmp_addr;
                    busy_nxt   = 1'b1;
                    rden_nxt   = 1'b1;
                    state_nxt  = FETCH;
`ifdef BMP_SCANOUT_LOOP_EN
                    stop_nxt   = 1'b0;
`endif
                end
            end
            FETCH: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                idx_nxt   = '0;
                last_nxt  = 1'b0;
                valid_nxt = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                if (row_ready) begin
                    if (row_last) begin
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                        if (stop_req) begin
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            rden_nxt  = 1'b1;
                            state_nxt = FETCH;
`ifdef BMP_SCANOUT_LOOP_EN
                            stop_nxt  = 1'b0;
`endif
                        end
                    end else begin
                        idx_nxt  = row_idx + IDX_W'(1);
                        last_nxt = (idx_nxt == IDX_W'(ROWS - 1));
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    bmp_row_mux u_row_mux (
        .buffer   (buffer),
        .row_idx  (row_idx),
        .row_data (row_data)
    );

endmodule

// File: tb/tb_bitmap_scanout.sv
// Bench for bitmap_scanout: timeline reference model plus directed and randomized scans.
module tb_bitmap_scanout;
    import bmp_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] bmp_addr;
    logic              busy, done, mem_rden, row_last, row_valid, row_ready;
    logic [ADDR_W-1:0] mem_rdaddr;
    logic [BMP_W-1:0]  mem_q = '0;
    logic [ROW_W-1:0]  row_data;
    logic [IDX_W-1:0]  row_idx;
`ifdef BMP_SCANOUT_LOOP_EN
    logic              loop_stop;
`endif

    bitmap_scanout dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bmp_addr   (bmp_addr),
`ifdef BMP_SCANOUT_LOOP_EN
        .loop_stop  (loop_stop),
`endif
        .busy       (busy),
        .done       (done),
        .mem_rdaddr (mem_rdaddr),
        .mem_rden   (mem_rden),
        .mem_q      (mem_q),
        .row_data   (row_data),
        .row_idx    (row_idx),
        .row_last   (row_last),
        .row_valid  (row_valid),
        .row_ready  (row_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rden_cnt = 0;
    int done_cnt = 0;

    logic [BMP_W-1:0] mem [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BMP_W-1:0] pat(input logic [15:0] a, input int ver);
        logic [BMP_W-1:0] img;
        for (int r = 0; r < ROWS; r++) begin
            img[r*ROW_W +: ROW_W] = {16'hA5A5 ^ 16'(ver), 16'(r),
                                     16'h5A5A ^ (16'(a ^ 16'd4) * 16'h0101)};
        end
        return img;
    endfunction

    // Synchronous read memory: data one cycle after the strobe
    always @(posedge clk) mem_q <= mem_rden ? mem[mem_rdaddr[3:0]] : '0;

    always @(posedge clk) begin
        if (mem_rden) rden_cnt++;
        if (done) done_cnt++;
    end

    // Reference model: a pass is a timeline counted from the read strobe
    bit               m_busy = 0, m_done = 0, m_rden = 0, m_valid = 0;
    int               m_row = 0, m_since = 0;
    logic [15:0]      m_addr = '0;
    logic [BMP_W-1:0] m_img = '0;
`ifdef BMP_SCANOUT_LOOP_EN
    bit               m_stop = 0;
`endif

    always @(posedge clk) begin
        bit stop_now;
        if (rst) begin
            m_busy = 0; m_done = 0; m_rden = 0; m_valid = 0;
            m_row = 0; m_since = 0; m_addr = '0;
        end else begin
            m_done = 0;
            m_rden = 0;
`ifdef BMP_SCANOUT_LOOP_EN
            stop_now = loop_stop | m_stop;
            if (m_busy) m_stop = stop_now;
`else
            stop_now = 1;
`endif
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_addr = bmp_addr; m_since = 0; m_rden = 1;
`ifdef BMP_SCANOUT_LOOP_EN
                    m_stop = 0;
`endif
                end
            end else if (m_since == 0) begin
                m_img = mem[m_addr[3:0]];
                m_since = 1;
            end else if (m_since == 1) begin
                m_since = 2; m_valid = 1; m_row = 0;
            end else if (row_ready) begin
                if (m_row == ROWS - 1) begin
                    m_valid = 0;
                    if (stop_now) begin
                        m_busy = 0; m_done = 1;
                    end else begin
                        m_since = 0; m_rden = 1;
`ifdef BMP_SCANOUT_LOOP_EN
                        m_stop = 0;
`endif
                    end
                end else begin
                    m_row++;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("mem_rden", 64'(mem_rden), 64'(m_rden));
        chk("mem_rdaddr", 64'(mem_rdaddr), 64'(m_addr));
        chk("row_valid", 64'(row_valid), 64'(m_valid));
        if (m_valid) begin
            chk("row_idx", 64'(row_idx), 64'(m_row));
            chk("row_last", 64'(row_last), 64'(m_row == ROWS - 1));
            chk("row_data", 64'(row_data), 64'(m_img[m_row*ROW_W +: ROW_W]));
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    // One scan from start to done (or to a planted reset)
    task automatic scan(input logic [15:0] a, input int stall_row, input int kick_row,
                        input int rst_row, input bit rnd,
                        output int beats, output int held, output bit aborted);
        int stall = 0;
        int cyc = 1;
        beats = 0; held = 0; aborted = 0;
        start = 1; bmp_addr = a;
        tick;
        start = 0; bmp_addr = 16'($urandom);
        while (!done && cyc < 400) begin
            start = 0;
            row_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (row_valid && row_idx == stall_row && stall < 5) begin
                row_ready = 0;
                stall++;
            end
            if (row_valid && row_idx == stall_row) held++;
            if (row_valid && row_ready) beats++;
            if (row_valid && row_ready && row_idx == kick_row) begin
                start = 1; bmp_addr = 16'd9;
            end
            if (row_valid && row_idx == rst_row) begin
                rst = 1;
                tick;
                rst = 0;
                aborted = 1;
                break;
            end
            tick;
            cyc++;
        end
        start = 0;
        row_ready = 1;
        if (cyc >= 400) chk("scan_timeout", 64'(cyc), 64'(0));
    endtask

    initial begin
        int n, beats, held;
        bit ab;
        rst = 1; start = 0; bmp_addr = '0; row_ready = 1;
`ifdef BMP_SCANOUT_LOOP_EN
        loop_stop = 0;
`endif
        for (int i = 0; i < 16; i++) mem[i] = pat(16'(i), 0);
        repeat (3) tick;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_valid", 64'(row_valid), 64'(0));
        chk("rst_idx", 64'(row_idx), 64'(0));
        chk("rst_rdaddr", 64'(mem_rdaddr), 64'(0));
        rst = 0;
        tick;

        // Basic latency and exact row contents
        rden_cnt = 0; done_cnt = 0;
        start = 1; bmp_addr = 16'h0004;
        tick;
        start = 0;
        chk("t1_rden", 64'(mem_rden), 64'(1));
        chk("t1_addr", 64'(mem_rdaddr), 64'h4);
        n = 1;
        while (!row_valid && n < 10) begin tick; n++; end
        chk("t1_first_lat", 64'(n), 64'(3));
        chk("t1_row0", 64'(row_data), 64'h0000_A5A5_0000_5A5A);
        while (!done && n < 100) begin
            if (row_valid && row_idx == 5'd31) chk("t1_row31", 64'(row_data), 64'h0000_A5A5_001F_5A5A);
            tick; n++;
        end
        chk("t1_done_lat", 64'(n), 64'(35));
        tick;
        chk("t1_rden_cnt", 64'(rden_cnt), 64'(1));
        chk("t1_done_cnt", 64'(done_cnt), 64'(1));

        // Back-pressure at row 7
        scan(16'd5, 7, -1, -1, 0, beats, held, ab);
        chk("t2_held7", 64'(held), 64'(6));
        chk("t2_beats", 64'(beats), 64'(32));
        tick;

        // Start while busy is ignored
        rden_cnt = 0; done_cnt = 0;
        scan(16'd6, -1, 10, -1, 0, beats, held, ab);
        tick;
        chk("t3_rden_cnt", 64'(rden_cnt), 64'(1));
        chk("t3_done_cnt", 64'(done_cnt), 64'(1));
        chk("t3_beats", 64'(beats), 64'(32));

        // Reset mid-stream abandons the scan
        rden_cnt = 0; done_cnt = 0;
        scan(16'd7, -1, -1, 15, 0, beats, held, ab);
        chk("t4_aborted", 64'(ab), 64'(1));
        chk("t4_busy", 64'(busy), 64'(0));
        chk("t4_valid", 64'(row_valid), 64'(0));
        chk("t4_idx", 64'(row_idx), 64'(0));
        repeat (3) tick;
        chk("t4_no_done", 64'(done_cnt), 64'(0));
        scan(16'd8, -1, -1, -1, 0, beats, held, ab);
        chk("t4_restart_beats", 64'(beats), 64'(32));

        // Start coincident with done is accepted
        start = 1; bmp_addr = 16'd10;
        tick;
        start = 0;
        chk("t5_rden", 64'(mem_rden), 64'(1));
        chk("t5_addr", 64'(mem_rdaddr), 64'd10);
        n = 0;
        while (!done && n < 100) begin tick; n++; end
        chk("t5_drain", 64'(n), 64'(34));
        tick;

        // Randomized back-pressure over random bitmaps
        for (int k = 0; k < 6; k++) begin
            mem[k + 8] = pat(16'(k + 8), k + 3);
            scan(16'($urandom_range(0, 15)), int'($urandom_range(0, 31)), -1, -1, 1, beats, held, ab);
            chk("rand_beats", 64'(beats), 64'(32));
            repeat ($urandom_range(0, 3)) tick;
        end

`ifdef BMP_SCANOUT_LOOP_EN
        // Looping: rewrite between passes, sticky stop in pass 3
        begin
            int pass = 0;
            bit seen0 = 0;
            rden_cnt = 0; done_cnt = 0;
            mem[4] = pat(16'd4, 0);
            start = 1; bmp_addr = 16'd4;
            tick;
            start = 0;
            n = 0;
            while (!done && n < 400) begin
                loop_stop = 0;
                if (mem_rden) pass++;
                if (pass == 1 && row_valid && row_idx == 5'd20) mem[4] = pat(16'd4, 1);
                if (pass == 2 && row_valid && row_idx == 5'd0 && !seen0) begin
                    chk("t6_pass2_row0", 64'(row_data), 64'h0000_A5A4_0000_5A5A);
                    seen0 = 1;
                end
                if (pass == 3 && row_valid && row_idx == 5'd5) loop_stop = 1;
                tick; n++;
            end
            loop_stop = 0;
            chk("t6_passes", 64'(pass), 64'(3));
            chk("t6_busy_at_done", 64'(busy), 64'(0));
            tick;
            chk("t6_done_cnt", 64'(done_cnt), 64'(1));
        end
`endif

        repeat (3) tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
